// File: rtl/operand_sequencer.sv
// Collects an x/y operand pair from one narrow valid/ready bus for the logic unit.
// Build with OPSEQ_ABORT_EN defined to add an abort input that drops a pending x.
module operand_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
`ifdef OPSEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_Y,
    FULL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_w;

`ifdef OPSEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    din_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          x_d     = din;
          state_d = WAIT_Y;
        end
      end
      WAIT_Y: begin
        // Abort wins over a beat arriving in the same cycle.
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          din_ready = 1'b1;
          if (din_valid) begin
            y_d     = din;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        out_valid = 1'b1;
        din_ready = out_ready;
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (din_valid) begin
            x_d     = din;
            state_d = WAIT_Y;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomized and directed bench for operand_sequencer against a beat-count model.
// Honours OPSEQ_ABORT_EN the same way as the design.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ab;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pair_count;

  int n_chk = 0;
  int n_pass = 0;

`ifdef OPSEQ_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  operand_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
`ifdef OPSEQ_ABORT_EN
    .abort     (ab),
`endif
    .x_out     (x_out),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  // Model: beats gathered into the current pair, the held pair, handoff total.
  int         nb;
  logic [3:0] mx, my;
  int         handoffs;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit exp_ready();
    if (nb == 2) return out_ready;
    if (nb == 1 && ABORT_ON && ab) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    nb = 0; mx = 0; my = 0; handoffs = 0;
  endtask

  task automatic check_all();
    check("din_ready", 32'(din_ready), 32'(exp_ready()));
    check("out_valid", 32'(out_valid), 32'(nb == 2));
    check("x_out", 32'(x_out), 32'(mx));
    check("y_out", 32'(y_out), 32'(my));
    check("pair_count", 32'(pair_count), 32'(handoffs % 256));
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic v, input logic [3:0] d,
                      input logic r, input logic a);
    bit rdy;
    din_valid = v; din = d; out_ready = r; ab = a;
    #3;
    check_all();
    rdy = exp_ready();
    @(posedge clk);
    if (nb == 1 && ABORT_ON && a) begin
      nb = 0;
    end else begin
      if (nb == 2 && r) begin
        nb = 0;
        handoffs++;
      end
      if (v && rdy) begin
        if (nb == 0) begin
          mx = d; nb = 1;
        end else begin
          my = d; nb = 2;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; din = 0; din_valid = 0; out_ready = 0; ab = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", 32'(x_out), 32'h0);
    check("rst_y", 32'(y_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_cnt", 32'(pair_count), 32'h0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(din_ready), 32'h1);
    @(posedge clk); #1;

    // Basic pair
    step(1, 4'hA, 0, 0);
    step(1, 4'h6, 0, 0);
    check("basic_x", 32'(x_out), 32'hA);
    check("basic_y", 32'(y_out), 32'h6);
    check("basic_valid", 32'(out_valid), 32'h1);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      step(1, 4'hF, 0, 0);
      check("bp_x", 32'(x_out), 32'hA);
      check("bp_y", 32'(y_out), 32'h6);
    end
    step(1, 4'hF, 1, 0);
    check("bp_newx", 32'(x_out), 32'hF);
    check("bp_cnt", 32'(pair_count), 32'h1);
    check("bp_wait_y", 32'(out_valid), 32'h0);

    // Close the F pair, then stream 1..6
    step(1, 4'h0, 1, 0);
    for (int i = 1; i <= 6; i++) step(1, 4'(i), 1, 0);
    check("stream_x", 32'(x_out), 32'h5);
    check("stream_y", 32'(y_out), 32'h6);
    step(0, 4'h0, 1, 0);
    check("stream_cnt", 32'(pair_count), 32'h5);

    // Reset mid-pair
    step(1, 4'h9, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_x", 32'(x_out), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_cnt", 32'(pair_count), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 4'h1, 0, 0);
    step(1, 4'h2, 0, 0);
    check("fresh_x", 32'(x_out), 32'h1);
    check("fresh_y", 32'(y_out), 32'h2);
    step(0, 4'h0, 1, 0);

`ifdef OPSEQ_ABORT_EN
    step(1, 4'h3, 0, 0);
    step(1, 4'h7, 0, 1);
    check("abort_idle", 32'(out_valid), 32'h0);
    step(1, 4'hC, 0, 0);
    step(1, 4'h5, 0, 0);
    check("abort_x", 32'(x_out), 32'hC);
    check("abort_y", 32'(y_out), 32'h5);
    check("abort_valid", 32'(out_valid), 32'h1);
    step(0, 4'h0, 1, 1);
`endif

    // Random traffic, long enough to wrap the 8-bit counter
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    check("wrapped", 32'(handoffs > 256), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
